// File: rtl/demux_stream_dispatcher.sv
// 1-to-N stream dispatcher: holds one beat and steers it to a single consumer,
// chosen by an explicit select or by strict round-robin rotation.
module demux_stream_dispatcher #(
    parameter int DW = 8,
    parameter int N  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode,
    input  logic [$clog2(N)-1:0]  sel_in,
    input  logic                  in_valid,
    input  logic [DW-1:0]         in_data,
    output logic                  in_ready,
    output logic [N-1:0]          out_valid,
    output logic [DW-1:0]         out_data,
    input  logic [N-1:0]          out_ready,
    output logic [$clog2(N)-1:0]  out_sel,
    output logic [7:0]            err_cnt
);

    localparam int            SW   = $clog2(N);
    localparam logic [SW:0]   N_W  = (SW+1)'(N);
    localparam logic [SW-1:0] LAST = SW'(N-1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic [SW-1:0] out_sel_q, out_sel_d;
    logic [SW-1:0] rr_ptr_q, rr_ptr_d;
    logic [7:0]    err_cnt_q, err_cnt_d;

    logic          accept_s;
    logic          deliver_s;
    logic          sel_ok_s;
    logic [SW-1:0] rr_inc_s;

    // State and datapath registers; reset wins over any accept/deliver.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            out_data_q <= '0;
            out_sel_q  <= '0;
            rr_ptr_q   <= '0;
            err_cnt_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            out_sel_q  <= out_sel_d;
            rr_ptr_q   <= rr_ptr_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // Next-state logic: capture, drop or deliver.
    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        out_sel_d  = out_sel_q;
        rr_ptr_d   = rr_ptr_q;
        err_cnt_d  = err_cnt_q;
        accept_s   = in_valid & in_ready;
        deliver_s  = (state_q == S_HOLD) & out_ready[out_sel_q];
        sel_ok_s   = ({1'b0, sel_in} < N_W);
        rr_inc_s   = (rr_ptr_q == LAST) ? '0 : rr_ptr_q + SW'(1);
        if (accept_s) begin
            if (mode) begin
                state_d    = S_HOLD;
                out_data_d = in_data;
                out_sel_d  = rr_ptr_q;
                rr_ptr_d   = rr_inc_s;
            end else if (sel_ok_s) begin
                state_d    = S_HOLD;
                out_data_d = in_data;
                out_sel_d  = sel_in;
            end else begin
                // Accept while holding implies the held beat completes now.
                state_d   = S_IDLE;
                err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
            end
        end else if (deliver_s) begin
            state_d = S_IDLE;
        end else begin
            state_d = state_q;
        end
    end

    // Output decode: one-hot valid and flow control from the held channel.
    always_comb begin
        out_valid = '0;
        in_ready  = 1'b1;
        if (state_q == S_HOLD) begin
            out_valid[out_sel_q] = 1'b1;
            in_ready             = out_ready[out_sel_q];
        end else begin
            out_valid = '0;
            in_ready  = 1'b1;
        end
    end

    assign out_data = out_data_q;
    assign out_sel  = out_sel_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_demux_stream_dispatcher.sv
// Directed table-driven bench for demux_stream_dispatcher (N=4 and N=3 instances).
module tb_demux_stream_dispatcher;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst4, mode4, vld4, rdy4_o;
    logic [1:0] sel4, osel4;
    logic [7:0] data4, odata4, err4;
    logic [3:0] rdy4, oval4;

    logic       rst3, mode3, vld3, rdy3_o;
    logic [1:0] sel3, osel3;
    logic [7:0] data3, odata3, err3;
    logic [2:0] rdy3, oval3;

    int checks = 0;
    int errors = 0;

    demux_stream_dispatcher #(.DW(8), .N(4)) u4 (
        .clk(clk), .rst(rst4), .mode(mode4), .sel_in(sel4), .in_valid(vld4),
        .in_data(data4), .in_ready(rdy4_o), .out_valid(oval4), .out_data(odata4),
        .out_ready(rdy4), .out_sel(osel4), .err_cnt(err4)
    );

    demux_stream_dispatcher #(.DW(8), .N(3)) u3 (
        .clk(clk), .rst(rst3), .mode(mode3), .sel_in(sel3), .in_valid(vld3),
        .in_data(data3), .in_ready(rdy3_o), .out_valid(oval3), .out_data(odata3),
        .out_ready(rdy3), .out_sel(osel3), .err_cnt(err3)
    );

    typedef struct {
        logic       rst;
        logic       mode;
        logic [1:0] sel;
        logic       vld;
        logic [7:0] data;
        logic [3:0] rdy;
        logic       e_ready;
        logic [3:0] e_valid;
        logic [7:0] e_data;
        logic [1:0] e_sel;
    } vec_t;

    vec_t tbl [29];

    function automatic vec_t v(input logic r, input logic m, input logic [1:0] s,
                               input logic vl, input logic [7:0] d, input logic [3:0] rd,
                               input logic er, input logic [3:0] ev,
                               input logic [7:0] ed, input logic [1:0] es);
        vec_t t;
        t.rst = r; t.mode = m; t.sel = s; t.vld = vl; t.data = d; t.rdy = rd;
        t.e_ready = er; t.e_valid = ev; t.e_data = ed; t.e_sel = es;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply3(input logic r, input logic m, input logic [1:0] s,
                          input logic vl, input logic [7:0] d, input logic [2:0] rd);
        @(negedge clk);
        rst3 = r; mode3 = m; sel3 = s; vld3 = vl; data3 = d; rdy3 = rd;
        #1;
    endtask

    initial begin
        // Each row: inputs applied before edge; expectations show state before that edge.
        tbl[0]  = v(0,0,1,1,8'hA5,4'b0000, 1,4'b0000,8'h00,0);
        tbl[1]  = v(0,0,0,0,8'h00,4'b0010, 1,4'b0010,8'hA5,1);
        tbl[2]  = v(0,0,0,0,8'h00,4'b0000, 1,4'b0000,8'hA5,1);
        tbl[3]  = v(0,1,0,1,8'h01,4'b1111, 1,4'b0000,8'hA5,1);
        tbl[4]  = v(0,1,0,1,8'h02,4'b1111, 1,4'b0001,8'h01,0);
        tbl[5]  = v(0,1,0,1,8'h03,4'b1111, 1,4'b0010,8'h02,1);
        tbl[6]  = v(0,1,0,1,8'h04,4'b1111, 1,4'b0100,8'h03,2);
        tbl[7]  = v(0,1,0,1,8'h05,4'b1111, 1,4'b1000,8'h04,3);
        tbl[8]  = v(0,1,0,0,8'h00,4'b1111, 1,4'b0001,8'h05,0);
        tbl[9]  = v(0,0,0,1,8'h11,4'b0000, 1,4'b0000,8'h05,0);
        for (int i = 10; i < 15; i++)
            tbl[i] = v(0,0,2,1,8'h22,4'b1110, 0,4'b0001,8'h11,0);
        tbl[15] = v(0,0,2,1,8'h22,4'b0001, 1,4'b0001,8'h11,0);
        tbl[16] = v(0,0,0,0,8'h00,4'b0100, 1,4'b0100,8'h22,2);
        tbl[17] = v(0,1,0,1,8'h31,4'b0000, 1,4'b0000,8'h22,2);
        tbl[18] = v(0,1,0,1,8'h32,4'b0010, 1,4'b0010,8'h31,1);
        tbl[19] = v(0,0,1,1,8'h33,4'b0000, 0,4'b0100,8'h32,2);
        tbl[20] = v(0,0,1,1,8'h33,4'b0100, 1,4'b0100,8'h32,2);
        tbl[21] = v(0,1,0,1,8'h34,4'b0010, 1,4'b0010,8'h33,1);
        tbl[22] = v(0,1,0,0,8'h00,4'b1000, 1,4'b1000,8'h34,3);
        tbl[23] = v(0,1,0,1,8'h41,4'b0000, 1,4'b0000,8'h34,3);
        tbl[24] = v(0,1,0,1,8'h42,4'b0000, 0,4'b0001,8'h41,0);
        tbl[25] = v(1,1,0,1,8'h43,4'b1111, 1,4'b0001,8'h41,0);
        tbl[26] = v(0,1,0,0,8'h00,4'b0000, 1,4'b0000,8'h00,0);
        tbl[27] = v(0,1,0,1,8'h51,4'b0000, 1,4'b0000,8'h00,0);
        tbl[28] = v(0,0,0,0,8'h00,4'b0001, 1,4'b0001,8'h51,0);

        rst4 = 1'b1; mode4 = 1'b0; sel4 = 2'd0; vld4 = 1'b0; data4 = 8'h00; rdy4 = 4'b0000;
        rst3 = 1'b1; mode3 = 1'b0; sel3 = 2'd0; vld3 = 1'b0; data3 = 8'h00; rdy3 = 3'b000;
        @(negedge clk);
        @(negedge clk);

        for (int i = 0; i < 29; i++) begin
            @(negedge clk);
            rst4 = tbl[i].rst; mode4 = tbl[i].mode; sel4 = tbl[i].sel;
            vld4 = tbl[i].vld; data4 = tbl[i].data; rdy4 = tbl[i].rdy;
            #1;
            chk($sformatf("row%0d in_ready", i), 32'(rdy4_o), 32'(tbl[i].e_ready));
            chk($sformatf("row%0d out_valid", i), 32'(oval4), 32'(tbl[i].e_valid));
            chk($sformatf("row%0d out_data", i), 32'(odata4), 32'(tbl[i].e_data));
            chk($sformatf("row%0d out_sel", i), 32'(osel4), 32'(tbl[i].e_sel));
            chk($sformatf("row%0d err_cnt", i), 32'(err4), 32'd0);
        end

        // N=3: sel_in=3 takes the drop path and counts, saturating at 255.
        apply3(1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 3'b000);
        apply3(1'b0, 1'b0, 2'd3, 1'b1, 8'h77, 3'b111);
        chk("n3 ready_idle", 32'(rdy3_o), 32'd1);
        chk("n3 err_reset", 32'(err3), 32'd0);
        apply3(1'b0, 1'b0, 2'd3, 1'b0, 8'h00, 3'b111);
        chk("n3 drop_valid", 32'(oval3), 32'd0);
        chk("n3 drop_data", 32'(odata3), 32'd0);
        chk("n3 err_one", 32'(err3), 32'd1);
        for (int k = 0; k < 299; k++)
            apply3(1'b0, 1'b0, 2'd3, 1'b1, 8'(k), 3'b111);
        apply3(1'b0, 1'b0, 2'd3, 1'b0, 8'h00, 3'b111);
        chk("n3 err_sat", 32'(err3), 32'd255);
        chk("n3 sat_valid", 32'(oval3), 32'd0);

        // N=3 round-robin wraps 2 -> 0 (rr_ptr was never advanced by drops).
        apply3(1'b0, 1'b1, 2'd0, 1'b1, 8'h01, 3'b111);
        for (int k = 0; k < 4; k++) begin
            logic [1:0] exp_sel;
            exp_sel = (k == 3) ? 2'd0 : 2'(k);
            apply3(1'b0, 1'b1, 2'd0, 1'b1, 8'(k + 2), 3'b111);
            chk($sformatf("n3 rr%0d sel", k), 32'(osel3), 32'(exp_sel));
            chk($sformatf("n3 rr%0d valid", k), 32'(oval3), 32'(3'b001 << exp_sel));
            chk($sformatf("n3 rr%0d data", k), 32'(odata3), 32'(k + 1));
        end

        // Drop while a held beat completes: held beat delivered, then IDLE.
        apply3(1'b0, 1'b0, 2'd3, 1'b1, 8'h99, 3'b111);
        chk("n3 held_sel", 32'(osel3), 32'd1);
        chk("n3 held_data", 32'(odata3), 32'h05);
        apply3(1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 3'b000);
        chk("n3 drop_hold_valid", 32'(oval3), 32'd0);
        chk("n3 drop_hold_data", 32'(odata3), 32'h05);
        chk("n3 drop_hold_err", 32'(err3), 32'd255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
